// File: rtl/sm3_msg_seq_pkg.sv
// Shared SM3 sequencer definitions: initial value, size limits, FSM states
// and the padded block-count rule.
package sm3_pkg;

  localparam int MAXBLK = 5;
  localparam int MAXLEN = MAXBLK * 512 - 65;

  localparam logic [255:0] SM3_IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  // Message, one '1' bit and a 64-bit length field must fit in n blocks.
  function automatic logic [2:0] blk_count(input logic [31:0] len);
    return 3'((len + 32'd64) >> 9) + 3'd1;
  endfunction

endpackage

// File: rtl/sm3_msg_seq_if.sv
// Handshake between the message sequencer and the single-block SM3
// compression core.
interface sm3_msg_seq_if;

  logic         cf_start;
  logic [511:0] cf_block;
  logic [255:0] cf_vin;
  logic [255:0] cf_vout;
  logic         cf_done;

  modport master (
    output cf_start,
    output cf_block,
    output cf_vin,
    input  cf_vout,
    input  cf_done
  );

  modport slave (
    input  cf_start,
    input  cf_block,
    input  cf_vin,
    output cf_vout,
    output cf_done
  );

endinterface

// File: rtl/sm3_msg_seq_pad.sv
// Combinational SM3 padding of a MAXBLK-block message image: keeps message
// bits below l, appends the marker bit and places the 64-bit length field.
module sm3_pad
  import sm3_pkg::*;
(
  input  logic [MAXBLK*512-1:0] msg,
  input  logic [31:0]           l,
  output logic [MAXBLK*512-1:0] img,
  output logic [2:0]            n
);

  localparam int W = MAXBLK * 512;
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MARK = {1'b1, {(W-1){1'b0}}};

  // Message bit i sits at vector bit W-1-i, so shifting right by l masks
  // the tail and lands the marker exactly at index l.
  always_comb begin
    n   = blk_count(l);
    img = (msg & ~(ONES >> l)) | (MARK >> l);
    for (int b = 0; b < MAXBLK; b++) begin
      if (b == int'(n) - 1) begin
        img[W - 512*(b+1) +: 64] = {32'd0, l};
      end
    end
  end

endmodule

// File: rtl/sm3_msg_seq.sv
// SM3 message sequencer: pads the message, feeds each block to an external
// compression core while chaining V, and presents the final digest.
module sm3_msg_seq #(
  parameter int MAXBLK = sm3_pkg::MAXBLK,
  parameter int MAXLEN = sm3_pkg::MAXLEN
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [511:0]  datain1,
  input  logic [511:0]  datain2,
  input  logic [511:0]  datain3,
  input  logic [511:0]  datain4,
  input  logic [511:0]  datain5,
  input  logic [31:0]   l,
  output logic [255:0]  hashout,
  output logic          valid,
  output logic          err,
  output logic          busy,
  sm3_msg_seq_if.master cf
);

  import sm3_pkg::*;

  localparam int IMG_W = MAXBLK * 512;

  state_t           state;
  logic [2:0]       blk;
  logic [2:0]       n_q;
  logic [2:0]       pad_n;
  logic [255:0]     v;
  logic [31:0]      l_q;
  logic [IMG_W-1:0] msg_q;
  logic [IMG_W-1:0] img_q;
  logic [IMG_W-1:0] pad_img;
  logic             accept;

  function automatic logic [511:0] block_of(input logic [IMG_W-1:0] img,
                                            input logic [2:0]       idx);
    return img[IMG_W - 512*(int'(idx)+1) +: 512];
  endfunction

  // A start coinciding with the valid pulse still belongs to the finishing
  // message and is dropped.
  assign accept = (state == IDLE) && start && !valid;

  sm3_pad u_pad (
    .msg (msg_q),
    .l   (l_q),
    .img (pad_img),
    .n   (pad_n)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      msg_q <= {datain1, datain2, datain3, datain4, datain5};
      l_q   <= l;
    end
    if (state == CHECK) begin
      img_q <= pad_img;
      n_q   <= pad_n;
    end
  end

  // Core-facing outputs are loaded on the edge that enters ISSUE, so
  // cf_start is visible during the ISSUE cycle itself.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      blk         <= '0;
      v           <= SM3_IV;
      hashout     <= '0;
      valid       <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      cf.cf_start <= 1'b0;
      cf.cf_block <= '0;
      cf.cf_vin   <= '0;
    end else begin
      valid       <= 1'b0;
      err         <= 1'b0;
      cf.cf_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (l_q > 32'(MAXLEN)) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            v           <= SM3_IV;
            blk         <= '0;
            cf.cf_block <= block_of(pad_img, 3'd0);
            cf.cf_vin   <= SM3_IV;
            cf.cf_start <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (cf.cf_done) begin
            v <= cf.cf_vout;
            if (blk == n_q - 3'd1) begin
              state <= DONE;
            end else begin
              blk         <= blk + 3'd1;
              cf.cf_block <= block_of(img_q, blk + 3'd1);
              cf.cf_vin   <= cf.cf_vout;
              cf.cf_start <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        DONE: begin
          hashout <= v;
          valid   <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_msg_seq.sv
// Bench for sm3_msg_seq: behavioural compression core with programmable
// latency plus a bit-level SM3 padding/chaining reference.
module tb_sm3_msg_seq;

  localparam logic [255:0] IV =
    256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [511:0] datain1, datain2, datain3, datain4, datain5;
  logic [31:0]  l;
  logic [255:0] hashout;
  logic         valid, err, busy;

  logic         core_done = 1'b0;
  logic [255:0] core_vout = '0;
  int           lat = 1;
  int           cnt = 0;
  int           unstable = 0;
  logic [511:0] cblk;
  logic [255:0] cvin;

  int           cyc = 0;
  int           st_q[$], dn_q[$], vl_q[$], er_q[$];
  logic         bz_q[$];
  logic [511:0] blk_q[$];
  logic [255:0] vin_q[$];

  int           tests = 0;
  int           fails = 0;

  logic [511:0] exp_blk[5];
  logic [255:0] exp_vin[5];
  int           exp_n;
  logic [255:0] exp_hash;

  always #5 clk = ~clk;

  sm3_msg_seq_if cf();
  assign cf.cf_done = core_done;
  assign cf.cf_vout = core_vout;

  sm3_msg_seq dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .datain1 (datain1),
    .datain2 (datain2),
    .datain3 (datain3),
    .datain4 (datain4),
    .datain5 (datain5),
    .l       (l),
    .hashout (hashout),
    .valid   (valid),
    .err     (err),
    .busy    (busy),
    .cf      (cf)
  );

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    return (s == 0) ? x : ((x << s) | (x >> (32 - s)));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol(x, 9) ^ rol(x, 17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol(x, 15) ^ rol(x, 23);
  endfunction

  function automatic logic [255:0] sm3_cf(input logic [255:0] vi, input logic [511:0] b);
    logic [31:0] w[68];
    logic [31:0] w1[64];
    logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, ff, gg;
    for (int j = 0; j < 16; j++) w[j] = b[511 - 32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rol(w[j-3], 15)) ^ rol(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
    {a, bb, c, d, e, f, g, h} = vi;
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rol(rol(a, 12) + e + rol(t, j), 7);
      ss2 = ss1 ^ rol(a, 12);
      ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
      gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ff + d + ss2 + w1[j];
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rol(bb, 9); bb = a; a = tt1;
      h = g; g = rol(f, 19); f = e; e = p0(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ vi;
  endfunction

  // Core model: result lat cycles after cf_start; unaware of the DUT's reset.
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (cnt > 0) begin
      if (rstn && (cf.cf_block !== cblk || cf.cf_vin !== cvin)) unstable <= unstable + 1;
      cnt <= cnt - 1;
      if (cnt == 1) begin
        core_done <= 1'b1;
        core_vout <= sm3_cf(cvin, cblk);
      end
    end else if (cf.cf_start) begin
      if (lat == 1) begin
        core_done <= 1'b1;
        core_vout <= sm3_cf(cf.cf_vin, cf.cf_block);
      end else begin
        cnt  <= lat - 1;
        cblk <= cf.cf_block;
        cvin <= cf.cf_vin;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cf.cf_start) begin
      st_q.push_back(cyc);
      blk_q.push_back(cf.cf_block);
      vin_q.push_back(cf.cf_vin);
    end
    if (cf.cf_done) dn_q.push_back(cyc);
    if (valid) vl_q.push_back(cyc);
    if (err) begin
      er_q.push_back(cyc);
      bz_q.push_back(busy);
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    st_q.delete(); dn_q.delete(); vl_q.delete(); er_q.delete();
    bz_q.delete(); blk_q.delete(); vin_q.delete();
  endtask

  function automatic logic [2559:0] rand_msg();
    logic [2559:0] m;
    for (int i = 0; i < 80; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  // Reference: build each padded block bit by bit, then chain compressions.
  task automatic ref_model(input logic [2559:0] msg, input int unsigned len);
    logic [511:0] b;
    logic [255:0] vv;
    exp_n = int'((len + 64) / 512 + 1);
    vv = IV;
    for (int k = 0; k < exp_n; k++) begin
      for (int j = 0; j < 512; j++) begin
        int unsigned idx;
        idx = k * 512 + j;
        b[511 - j] = (idx < len) ? msg[2559 - idx] : (idx == len);
      end
      if (k == exp_n - 1) b[63:0] = 64'(len);
      exp_blk[k] = b;
      exp_vin[k] = vv;
      vv = sm3_cf(vv, b);
    end
    exp_hash = vv;
  endtask

  task automatic run(input string tag, input logic [2559:0] msg, input logic [31:0] len,
                     input bit poke);
    int t0, waitc, unst0;
    logic [255:0] prev;
    bit expect_err;
    prev = hashout;
    expect_err = (len > 32'd2495);
    if (!expect_err) ref_model(msg, len);
    clear_logs();
    unst0 = unstable;
    {datain1, datain2, datain3, datain4, datain5} = msg;
    l = len;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    waitc = 0;
    while (vl_q.size() == 0 && er_q.size() == 0 && waitc < 1500) begin
      start = 1'b0;
      if (poke) begin
        if (cyc == t0 + 5) begin start = 1'b1; l = 32'd24; end
        if (dn_q.size() == exp_n) begin
          if (cyc == dn_q[exp_n-1] + 2) begin start = 1'b1; l = 32'd24; end
        end
      end
      tick();
      waitc++;
    end
    start = 1'b0;
    chk({tag, "/completes"}, waitc < 1500, 1'b1);
    repeat (8) tick();
    if (expect_err) begin
      chk({tag, "/err_count"}, er_q.size(), 1);
      if (er_q.size() > 0) begin
        chk({tag, "/err_cycle"}, er_q[0], t0 + 2);
        chk({tag, "/busy_at_err"}, bz_q[0], 1'b0);
      end
      chk({tag, "/no_cf_start"}, st_q.size(), 0);
      chk({tag, "/no_valid"}, vl_q.size(), 0);
      chk({tag, "/hash_kept"}, hashout, prev);
    end else begin
      chk({tag, "/cf_starts"}, st_q.size(), exp_n);
      chk({tag, "/valid_count"}, vl_q.size(), 1);
      chk({tag, "/no_err"}, er_q.size(), 0);
      chk({tag, "/hash"}, hashout, exp_hash);
      chk({tag, "/stable"}, unstable - unst0, 0);
      if (st_q.size() > 0) chk({tag, "/first_start"}, st_q[0], t0 + 2);
      for (int k = 0; k < exp_n && k < st_q.size(); k++) begin
        chk($sformatf("%s/block%0d", tag, k), blk_q[k], exp_blk[k]);
        chk($sformatf("%s/vin%0d", tag, k), vin_q[k], exp_vin[k]);
        if (k > 0 && k <= dn_q.size())
          chk($sformatf("%s/gap%0d", tag, k), st_q[k], dn_q[k-1] + 1);
      end
      if (vl_q.size() > 0 && dn_q.size() >= exp_n)
        chk({tag, "/valid_cycle"}, vl_q[0], dn_q[exp_n-1] + 2);
    end
  endtask

  initial begin
    logic [2559:0] m;
    int waitc;
    rstn = 1'b0; start = 1'b0; l = '0;
    datain1 = '0; datain2 = '0; datain3 = '0; datain4 = '0; datain5 = '0;
    repeat (3) tick();
    chk("rst/hashout", hashout, 256'd0);
    chk("rst/valid", valid, 1'b0);
    chk("rst/err", err, 1'b0);
    chk("rst/busy", busy, 1'b0);
    chk("rst/cf_start", cf.cf_start, 1'b0);
    chk("rst/cf_block", cf.cf_block, 512'd0);
    chk("rst/cf_vin", cf.cf_vin, 256'd0);
    rstn = 1'b1;
    tick();

    lat = 1;
    m = '0; m[2559 -: 24] = 24'h616263;
    run("abc", m, 32'd24, 1'b0);
    chk("abc/known", hashout,
        256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0);
    chk("abc/one_block", st_q.size(), 1);

    lat = 65;
    m = '0; m[2559 -: 512] = {16{32'h61626364}};
    run("abcd16", m, 32'd512, 1'b0);
    chk("abcd16/known", hashout,
        256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732);
    chk("abcd16/two_blocks", st_q.size(), 2);

    lat = 1;
    run("l0", rand_msg(), 32'd0, 1'b0);
    chk("l0/known", hashout,
        256'h1ab21d8355cfa17f8e61194831e81a8f22bec8c728fefb747ed035eb5082aa2b);

    run("l447", rand_msg(), 32'd447, 1'b0);
    chk("l447/blocks", st_q.size(), 1);
    run("l448", rand_msg(), 32'd448, 1'b0);
    chk("l448/blocks", st_q.size(), 2);

    lat = 3;
    run("l2495", rand_msg(), 32'd2495, 1'b0);
    chk("l2495/blocks", st_q.size(), 5);
    if (blk_q.size() == 5) chk("l2495/lenfield", blk_q[4][63:0], 64'h9BF);

    run("l2496", rand_msg(), 32'd2496, 1'b0);
    run("lmax32", rand_msg(), 32'hFFFF_FFFF, 1'b0);

    lat = 65;
    run("ignore_start", rand_msg(), 32'd600, 1'b1);

    // Abort a 3-block message while the core still owes block 2's result.
    clear_logs();
    m = rand_msg();
    {datain1, datain2, datain3, datain4, datain5} = m;
    l = 32'd1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitc = 0;
    while (st_q.size() < 2 && waitc < 1500) begin tick(); waitc++; end
    chk("abort/reached_block2", waitc < 1500, 1'b1);
    repeat (5) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (80) tick();
    chk("abort/stray_done_seen", dn_q.size(), 2);
    chk("abort/no_valid", vl_q.size(), 0);
    chk("abort/no_more_start", st_q.size(), 2);
    chk("abort/hashout", hashout, 256'd0);
    chk("abort/busy", busy, 1'b0);
    chk("abort/cf_block", cf.cf_block, 512'd0);
    chk("abort/cf_vin", cf.cf_vin, 256'd0);

    lat = 1;
    m = '0; m[2559 -: 24] = 24'h616263;
    run("abc_after_abort", m, 32'd24, 1'b0);
    chk("abc_after_abort/known", hashout,
        256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0);

    m = rand_msg();
    lat = 1;
    run("lat1", m, 32'd1200, 1'b0);
    lat = 65;
    run("lat65", m, 32'd1200, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

endmodule
